wb_pipe_interface: RTL
======================

WB_PIPE_INTERFACE -- requirements
Module: wb_pipe_interface

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter ADDR_WIDTH, default 8: word-address width; the memory depth is 2^ADDR_WIDTH 32-bit words.
REQ-003 Parameter READ_LATENCY, default 1, legal range 1..4: cycles from read_o to valid read_data_i.
REQ-004 Parameter MAX_OUTSTANDING, default READ_LATENCY, legal range 1..READ_LATENCY: maximum number of accepted, un-acknowledged requests.
REQ-005 The ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-low.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error response.
- wb_stall_o  out  1  pipelined stall.
- addr_o  out  ADDR_WIDTH  memory word address.
- read_o  out  1  memory read strobe.
- read_data_i  in  32  memory read data.
- write_o  out  1  memory write strobe.
- write_data_o  out  32  memory write data.
- write_sel_o  out  4  memory byte enables.

Function
REQ-006 A request SHALL be accepted in cycle T when wb_cyc_i=1, wb_stb_i=1 and wb_stall_o=0; one request is accepted per cycle at most.
REQ-007 addr_o SHALL equal wb_adr_i[ADDR_WIDTH+1:2]; write_data_o SHALL equal wb_dat_i; write_sel_o SHALL equal wb_sel_i; all three are combinational.
REQ-008 A request SHALL be in range iff wb_adr_i[31:ADDR_WIDTH+2]==0.
REQ-009 On an accepted in-range read, read_o SHALL be 1 in cycle T; on an accepted in-range write, write_o SHALL be 1 in cycle T; both are combinational.
REQ-010 For an out-of-range request, or any non-accepted cycle, read_o and write_o SHALL be 0.
REQ-011 Each accepted request SHALL enter a READ_LATENCY-deep in-flight pipeline carrying a valid, we and err flag.
REQ-012 Exactly one response SHALL be asserted in cycle T+READ_LATENCY, for reads and writes alike: wb_ack_o for in-range requests, wb_err_o for out-of-range requests.
REQ-013 wb_ack_o and wb_err_o SHALL be registered and never asserted together.
REQ-014 Responses SHALL be returned strictly in acceptance order; back-to-back accepted requests yield back-to-back responses.
REQ-015 wb_dat_o SHALL equal read_data_i in a read-ack cycle and 0 otherwise.
REQ-016 An outstanding counter SHALL increment on accept, decrement on response, and hold on a simultaneous accept and response.
REQ-017 wb_stall_o SHALL be 1 iff counter==MAX_OUTSTANDING and no response is issued in the current cycle (combinational).
REQ-018 Abort: wb_cyc_i=0 in any cycle SHALL clear all in-flight entries and the counter at the next edge.
- Responses still in flight SHALL then never be issued.
- Memory writes already strobed are not undone.
REQ-019 A request presented in the same cycle as wb_cyc_i=0 SHALL NOT be accepted.
REQ-020 wb_stall_o SHALL remain 0 when MAX_OUTSTANDING==READ_LATENCY.

Reset
REQ-021 While rst_i=0 at a clock edge, the pipeline and counter SHALL clear, and wb_ack_o=0 and wb_err_o=0 from the next cycle.
REQ-022 While rst_i=0, wb_stall_o SHALL be 1, and read_o and write_o SHALL be 0.
REQ-023 Reset mid-transfer SHALL discard all outstanding responses; the first accept is possible in the first cycle after rst_i returns to 1.

Verification
REQ-024 Single read, L=1: adr=0x10, we=0 -> read_o=1, addr_o=0x04 in cycle T; ack=1 and wb_dat_o=read_data_i in cycle T+1.
REQ-025 Burst, L=3: 4 back-to-back reads at 0x0/0x4/0x8/0xC -> acks in cycles T+3..T+6 with data in order; stall=0 throughout.
REQ-026 Stall, L=3, MAX_OUTSTANDING=1: continuous stb -> one accept every 3 cycles, with wb_stall_o=1 in the two intervening cycles.
REQ-027 Error, ADDR_WIDTH=8: write to 0x400 with sel=0xF -> write_o=0; err=1 and ack=0 at T+L; the following in-range read acks normally.
REQ-028 Abort, L=3: 2 reads accepted, cyc dropped at T+1 -> no ack or err ever; counter=0; a new cycle acks normally.
REQ-029 Byte write, L=1: adr=0x8, sel=0x2, dat=0xAABBCCDD -> write_o=1, write_sel_o=0x2, addr_o=0x02, write_data_o=0xAABBCCDD; ack at T+1.

Source files
------------

// File: rtl/wb_pipe_interface.sv
`default_nettype none
// ============================================================================
// Module   : wb_pipe_interface
// Brief    : Pipelined Wishbone slave bridging to a fixed-latency 32-bit memory.
// Revision : 1.0 - initial release
// ============================================================================
module wb_pipe_interface #(
  parameter int ADDR_WIDTH      = 8,
  parameter int READ_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = READ_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  read_o,
  input  logic [31:0]           read_data_i,
  output logic                  write_o,
  output logic [31:0]           write_data_o,
  output logic [3:0]            write_sel_o
);

  localparam int                 c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_OUTSTANDING);

  // One bit per in-flight slot; the last slot drives the response directly.
  logic [READ_LATENCY-1:0] r_ack_pipe;
  logic [READ_LATENCY-1:0] r_err_pipe;
  logic [READ_LATENCY-1:0] r_rd_pipe;
  logic [c_CNT_W-1:0]      r_count;

  logic w_in_range;
  logic w_accept;
  logic w_resp;
  logic w_unused;

  assign w_in_range = (wb_adr_i >> (ADDR_WIDTH + 2)) == 32'd0;
  assign w_resp     = r_ack_pipe[READ_LATENCY-1] | r_err_pipe[READ_LATENCY-1];

  // Stall is forced during reset so nothing is accepted while rst_i is low.
  assign wb_stall_o = !rst_i || ((r_count == c_MAX) && !w_resp);
  assign w_accept   = wb_cyc_i && wb_stb_i && !wb_stall_o;

  assign addr_o       = wb_adr_i[ADDR_WIDTH+1:2];
  assign write_data_o = wb_dat_i;
  assign write_sel_o  = wb_sel_i;
  assign read_o       = w_accept && w_in_range && !wb_we_i;
  assign write_o      = w_accept && w_in_range && wb_we_i;

  assign wb_ack_o = r_ack_pipe[READ_LATENCY-1];
  assign wb_err_o = r_err_pipe[READ_LATENCY-1];
  assign wb_dat_o = r_rd_pipe[READ_LATENCY-1] ? read_data_i : 32'd0;

  assign w_unused = ^wb_adr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i || !wb_cyc_i) begin
      r_ack_pipe <= '0;
      r_err_pipe <= '0;
      r_rd_pipe  <= '0;
      r_count    <= '0;
    end else begin
      r_ack_pipe <= (r_ack_pipe << 1) | READ_LATENCY'(w_accept && w_in_range);
      r_err_pipe <= (r_err_pipe << 1) | READ_LATENCY'(w_accept && !w_in_range);
      r_rd_pipe  <= (r_rd_pipe << 1)  | READ_LATENCY'(w_accept && w_in_range && !wb_we_i);
      case ({w_accept, w_resp})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
